// File: rtl/dp_rr_sched.sv
// dp_rr_sched - round-robin scheduler sharing one datapath among NUM_REQ requesters.
//
// Grants one requester at a time for a bounded burst, muxes its data onto the
// shared datapath input and sequences valid/ready beats. Each grant is followed
// by exactly one dead cycle, so the datapath never sees back-to-back beats from
// different requesters.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req             per-requester request level, held while data is pending
//   req_data        packed per-requester data, slice i = [i*DATA_W2 +: DATA_W2]
//   req_last        per-requester last-beat marker, qualified with the beat
//   gnt, gnt_id     registered one-hot grant and index of current/last grant
//   dp_data_in      data to the shared datapath (holds last driven value)
//   dp_valid        beat valid to the datapath
//   dp_ready        datapath accepts beat
//   busy            high whenever the scheduler is not idle
//   timeout_err     single-cycle pulse when a stalled burst is aborted
//
// Build option: define SCHED_TIMEOUT_EN to abort bursts stalled for TIMEOUT
// consecutive cycles; otherwise a burst waits indefinitely for dp_ready.
module dp_rr_sched #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W2   = 5,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W2-1:0] req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic [DATA_W2-1:0]         dp_data_in,
    output logic                       dp_valid,
    input  logic                       dp_ready,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);
    localparam int unsigned BC_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [BC_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [DATA_W2-1:0]   hold_q, hold_d;
    logic                 busy_q, busy_d;

    logic [DATA_W2-1:0]   slice [NUM_REQ];
    logic [DATA_W2-1:0]   cur_data;
    logic                 cur_req;
    logic                 cur_last;
    logic                 xfer;
    logic                 burst_end;
    logic                 found;
    logic [ID_W-1:0]      win;

`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned TC_W = $clog2(TIMEOUT + 1);
    logic [TC_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic                 tmo_q, tmo_d;
`else
    // TIMEOUT is accepted for a uniform interface but has no effect in this build.
    if (TIMEOUT == 0) begin : g_timeout_unused
    end
`endif

    // Unpack the per-requester data slices.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign slice[i] = req_data[i*DATA_W2 +: DATA_W2];
    end

    // Signals of the currently granted requester.
    assign cur_req  = req[gnt_id_q];
    assign cur_last = req_last[gnt_id_q];
    assign cur_data = slice[gnt_id_q];

    assign dp_valid   = (state_q == ST_BURST) && cur_req;
    assign dp_data_in = dp_valid ? cur_data : hold_q;
    assign xfer       = dp_valid && dp_ready;

    // Round-robin search starting just after the last winner.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!found && req[(32'(ptr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = ID_W'((32'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        hold_d     = hold_q;
        burst_end  = 1'b0;
`ifdef SCHED_TIMEOUT_EN
        stall_cnt_d = stall_cnt_q;
        tmo_d       = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d    = ST_BURST;
                    gnt_d      = NUM_REQ'(1) << win;
                    gnt_id_d   = win;
                    ptr_d      = win;
                    beat_cnt_d = '0;
                end
            end

            ST_BURST: begin
                if (dp_valid) begin
                    hold_d = cur_data;
                end
                if (xfer) begin
                    if (beat_cnt_q != BC_W'(MAX_BURST)) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                    // Last marker and MAX_BURST together still give a single end.
                    if (cur_last || (beat_cnt_q == BC_W'(MAX_BURST - 1))) begin
                        burst_end = 1'b1;
                    end
                end else if (!cur_req) begin
                    // Requester withdrew with nothing valid.
                    burst_end = 1'b1;
                end
`ifdef SCHED_TIMEOUT_EN
                else begin
                    // Valid but stalled; a transfer would have reset the count instead.
                    if (stall_cnt_q == TC_W'(TIMEOUT - 1)) begin
                        burst_end = 1'b1;
                        tmo_d     = 1'b1;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end
                if (xfer) begin
                    stall_cnt_d = '0;
                end
`endif
                if (burst_end) begin
                    state_d    = ST_RELEASE;
                    gnt_d      = '0;
                    beat_cnt_d = '0;
`ifdef SCHED_TIMEOUT_EN
                    stall_cnt_d = '0;
`endif
                end
            end

            ST_RELEASE: begin
                state_d    = ST_IDLE;
                gnt_d      = '0;
                beat_cnt_d = '0;
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            ptr_q      <= ID_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
            hold_q     <= '0;
            busy_q     <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            stall_cnt_q <= '0;
            tmo_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
`ifdef SCHED_TIMEOUT_EN
            stall_cnt_q <= stall_cnt_d;
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;

`ifdef SCHED_TIMEOUT_EN
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dp_rr_sched.sv
// Testbench for dp_rr_sched: directed scenarios followed by a randomized phase,
// all checked against a transaction-level model of the requesters and scheduler.
module tb_dp_rr_sched;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned DATA_W2   = 5;
    localparam int unsigned MAX_BURST = 8;
    localparam int unsigned TIMEOUT   = 15;
    localparam int unsigned ID_W      = $clog2(NUM_REQ);
    localparam int unsigned QD        = 32;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DATA_W2-1:0] req_data;
    logic [NUM_REQ-1:0]         req_last;
    logic [NUM_REQ-1:0]         gnt;
    logic [ID_W-1:0]            gnt_id;
    logic [DATA_W2-1:0]         dp_data_in;
    logic                       dp_valid;
    logic                       dp_ready;
    logic                       busy;
    logic                       timeout_err;

    dp_rr_sched #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W2  (DATA_W2),
        .MAX_BURST(MAX_BURST),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .req_last   (req_last),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .dp_data_in (dp_data_in),
        .dp_valid   (dp_valid),
        .dp_ready   (dp_ready),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Requester beat queues (circular buffers).
    logic [DATA_W2-1:0] qd [NUM_REQ][QD];
    logic               ql [NUM_REQ][QD];
    int                 qh [NUM_REQ];
    int                 qn [NUM_REQ];
    int                 drop_left [NUM_REQ];

    int total;
    int bad;

    // Scheduler model: owner (-1 none), dead cycle flag, last grant, RR pointer.
    int                 m_owner;
    int                 m_last_id;
    int                 m_ptr;
    int                 m_beats;
    bit                 m_dead;
    bit                 m_tmo;
    logic [DATA_W2-1:0] m_data;
`ifdef SCHED_TIMEOUT_EN
    int                 m_stall;
`endif

    // Observed grant log.
    int g_n;
    int g_id [64];
    int g_beats [64];
    int cur_beats;
    bit open_g;
    bit prev_valid;
    int cyc;
    int valid_rise_cyc;
    int tmo_cyc;
    int tmo_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic [DATA_W2-1:0] d, input logic l);
        qd[i][(qh[i] + qn[i]) % QD] = d;
        ql[i][(qh[i] + qn[i]) % QD] = l;
        qn[i]++;
    endtask

    task automatic load(input int i, input int len, input bit with_last);
        for (int b = 0; b < len; b++) begin
            push(i, DATA_W2'($urandom), with_last && (b == len - 1));
        end
    endtask

    task automatic pop(input int i);
        qh[i] = (qh[i] + 1) % QD;
        qn[i]--;
        if (drop_left[i] != 0) begin
            drop_left[i]--;
            if (drop_left[i] == 0) qn[i] = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i] = (qn[i] != 0);
            if (qn[i] != 0) begin
                req_data[i*DATA_W2 +: DATA_W2] = qd[i][qh[i]];
                req_last[i] = ql[i][qh[i]];
            end else begin
                req_data[i*DATA_W2 +: DATA_W2] = DATA_W2'($urandom);
                req_last[i] = 1'($urandom);
            end
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_last_id = 0;
        m_ptr     = NUM_REQ - 1;
        m_beats   = 0;
        m_dead    = 1'b0;
        m_tmo     = 1'b0;
        m_data    = '0;
`ifdef SCHED_TIMEOUT_EN
        m_stall   = 0;
`endif
    endtask

    task automatic clear_log();
        g_n            = 0;
        cur_beats      = 0;
        open_g         = 1'b0;
        prev_valid     = 1'b0;
        valid_rise_cyc = -1;
        tmo_cyc        = -1;
        tmo_count      = 0;
    endtask

    // Expected outputs for the current cycle, derived from the model state.
    task automatic check_outputs();
        logic [NUM_REQ-1:0] e_gnt;
        logic               e_valid;
        logic [DATA_W2-1:0] e_data;
        e_gnt   = '0;
        e_valid = 1'b0;
        e_data  = m_data;
        if (m_owner >= 0) begin
            e_gnt[m_owner] = 1'b1;
            e_valid = (qn[m_owner] != 0);
            if (e_valid) e_data = qd[m_owner][qh[m_owner]];
        end
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("gnt_id", 32'(gnt_id), 32'(m_last_id));
        chk("dp_valid", 32'(dp_valid), 32'(e_valid));
        chk("dp_data_in", 32'(dp_data_in), 32'(e_data));
        chk("busy", 32'(busy), 32'((m_owner >= 0) || m_dead));
        chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
    endtask

    task automatic log_outputs();
        if (gnt != '0 && !open_g) begin
            open_g    = 1'b1;
            cur_beats = 0;
            for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) g_id[g_n] = i;
        end
        if (open_g && dp_valid && dp_ready) cur_beats++;
        if (gnt == '0 && open_g) begin
            g_beats[g_n] = cur_beats;
            if (g_n < 63) g_n++;
            open_g = 1'b0;
        end
        if (dp_valid && !prev_valid && valid_rise_cyc < 0) valid_rise_cyc = cyc;
        prev_valid = dp_valid;
        if (timeout_err) begin
            tmo_count++;
            tmo_cyc = cyc;
        end
    endtask

    // Advance the model over one clock edge using the inputs of this cycle.
    task automatic model_step();
        bit nxt_tmo = 1'b0;
        bit fin = 1'b0;
        if (m_dead) begin
            m_dead = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int idx = (m_ptr + k) % NUM_REQ;
                if (m_owner < 0 && qn[idx] != 0) begin
                    m_owner   = idx;
                    m_ptr     = idx;
                    m_last_id = idx;
                    m_beats   = 0;
`ifdef SCHED_TIMEOUT_EN
                    m_stall   = 0;
`endif
                end
            end
        end else if (qn[m_owner] == 0) begin
            fin = 1'b1;
        end else begin
            m_data = qd[m_owner][qh[m_owner]];
            if (dp_ready) begin
                m_beats++;
`ifdef SCHED_TIMEOUT_EN
                m_stall = 0;
`endif
                if (ql[m_owner][qh[m_owner]] || m_beats == MAX_BURST) fin = 1'b1;
                pop(m_owner);
            end else begin
`ifdef SCHED_TIMEOUT_EN
                m_stall++;
                if (m_stall == TIMEOUT) begin
                    fin     = 1'b1;
                    nxt_tmo = 1'b1;
                end
`endif
            end
        end
        if (fin) begin
            m_owner = -1;
            m_dead  = 1'b1;
        end
        m_tmo = nxt_tmo;
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        check_outputs();
        log_outputs();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        dp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            qn[i]        = 0;
            qh[i]        = 0;
            drop_left[i] = 0;
        end
        drive();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int exp_order [5];
        total    = 0;
        bad      = 0;
        cyc      = 0;
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        req_last = '0;
        dp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            qn[i] = 0; qh[i] = 0; drop_left[i] = 0;
        end
        model_reset();
        clear_log();
        #1;

        // Single requester, 3-beat burst with last.
        do_reset();
        load(0, 3, 1'b1);
        dp_ready = 1'b1;
        repeat (8) cycle();
        chk("s1_grants", 32'(g_n), 32'd1);
        chk("s1_id", 32'(g_id[0]), 32'd0);
        chk("s1_beats", 32'(g_beats[0]), 32'd3);

        // All requesting, bursts of 2: grant order 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) repeat (3) load(i, 2, 1'b1);
        dp_ready = 1'b1;
        for (int t = 0; t < 80 && g_n < 5; t++) cycle();
        exp_order = '{0, 1, 2, 3, 0};
        chk("s2_grants_seen", 32'(g_n >= 5), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("s2_order", 32'(g_id[k]), 32'(exp_order[k]));
            chk("s2_beats", 32'(g_beats[k]), 32'd2);
        end

        // 20 beats without last: bursts capped at MAX_BURST.
        do_reset();
        load(2, 20, 1'b0);
        dp_ready = 1'b1;
        for (int t = 0; t < 100 && g_n < 3; t++) cycle();
        chk("s3_grants_seen", 32'(g_n >= 3), 32'd1);
        chk("s3_id0", 32'(g_id[0]), 32'd2);
        chk("s3_id1", 32'(g_id[1]), 32'd2);
        chk("s3_beats0", 32'(g_beats[0]), 32'd8);
        chk("s3_beats1", 32'(g_beats[1]), 32'd8);
        chk("s3_beats2", 32'(g_beats[2]), 32'd4);

        // Long stall after grant.
        do_reset();
        load(0, 3, 1'b1);
        load(1, 2, 1'b1);
        dp_ready = 1'b0;
        repeat (22) cycle();
`ifdef SCHED_TIMEOUT_EN
        chk("s4_tmo_count", 32'(tmo_count), 32'd1);
        chk("s4_tmo_delay", 32'(tmo_cyc - valid_rise_cyc), 32'(TIMEOUT));
        dp_ready = 1'b1;
        for (int t = 0; t < 40 && g_n < 2; t++) cycle();
        chk("s4_first_id", 32'(g_id[0]), 32'd0);
        chk("s4_first_beats", 32'(g_beats[0]), 32'd0);
        chk("s4_next_id", 32'(g_id[1]), 32'd1);
`else
        chk("s4_no_tmo", 32'(tmo_count), 32'd0);
        chk("s4_still_gnt", 32'(gnt), 32'd1);
        chk("s4_still_valid", 32'(dp_valid), 32'd1);
`endif

        // Asynchronous reset mid-burst after 3 of 6 beats.
        do_reset();
        load(0, 6, 1'b1);
        load(2, 2, 1'b1);
        dp_ready = 1'b1;
        for (int t = 0; t < 20 && qn[0] > 3; t++) cycle();
        chk("s5_three_beats", 32'(qn[0]), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("s5_rst_gnt", 32'(gnt), 32'd0);
        chk("s5_rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("s5_rst_valid", 32'(dp_valid), 32'd0);
        chk("s5_rst_data", 32'(dp_data_in), 32'd0);
        chk("s5_rst_busy", 32'(busy), 32'd0);
        chk("s5_rst_tmo", 32'(timeout_err), 32'd0);
        do_reset();
        load(1, 2, 1'b1);
        load(0, 2, 1'b1);
        dp_ready = 1'b1;
        for (int t = 0; t < 20 && g_n < 1; t++) cycle();
        chk("s5_first_id", 32'(g_id[0]), 32'd0);

        // Requester 1 withdraws after 2 beats; requester 3 pending.
        do_reset();
        load(1, 5, 1'b0);
        drop_left[1] = 2;
        load(3, 3, 1'b1);
        dp_ready = 1'b1;
        for (int t = 0; t < 30 && g_n < 2; t++) cycle();
        chk("s6_id0", 32'(g_id[0]), 32'd1);
        chk("s6_beats0", 32'(g_beats[0]), 32'd2);
        chk("s6_id1", 32'(g_id[1]), 32'd3);
        chk("s6_beats1", 32'(g_beats[1]), 32'd3);

        // Randomized traffic against the model.
        do_reset();
        for (int t = 0; t < 900; t++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (qn[i] == 0 && ($urandom % 6) == 0) begin
                    int len = int'($urandom_range(1, 12));
                    load(i, len, ($urandom % 4) != 0);
                    if (($urandom % 8) == 0) drop_left[i] = int'($urandom_range(1, len));
                end
            end
            if ((t / 100) % 3 == 2) dp_ready = ($urandom % 16) == 0;
            else                    dp_ready = ($urandom % 4) != 0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dp_rr_sched.md
Name: dp_rr_sched

Overview:
- Round-robin scheduler that shares one datapath instance (data_in/data_en style) among NUM_REQ requesters.
- Grants one requester at a time for a bounded burst.
- Muxes the granted requester's data onto the datapath input and sequences valid/ready beats.
- Sits between the requester blocks and the shared module instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W2, 5, datapath data width in bits
- MAX_BURST, 8, maximum beats per grant (1..255)
- TIMEOUT, 15, consecutive stalled cycles before a burst aborts (1..255; only with SCHED_TIMEOUT_EN)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- req  input  NUM_REQ  per-requester request; level, held while data is pending
- req_data  input  NUM_REQ*DATA_W2  packed per-requester data; slice i = [i*DATA_W2 +: DATA_W2]
- req_last  input  NUM_REQ  per-requester last-beat marker, qualified with the beat
- gnt  output  NUM_REQ  registered one-hot grant; a beat of requester i is consumed when gnt[i] && dp_ready
- gnt_id  output  $clog2(NUM_REQ)  index of current or last grant
- dp_data_in  output  DATA_W2  data to the shared datapath
- dp_valid  output  1  beat valid to the datapath
- dp_ready  input  1  datapath accepts beat
- busy  output  1  high in any state other than IDLE
- timeout_err  output  1  single-cycle pulse on burst abort

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; gnt=0, gnt_id=0, dp_valid=0, dp_data_in=0, busy=0, timeout_err=0.
  - RR pointer = NUM_REQ-1, so requester 0 wins first.
  - beat counter and stall counter = 0.
- Reset asserted mid-burst takes effect immediately. The partially transferred burst is abandoned, with no completion beat.
- FSM has three states: IDLE, BURST, RELEASE.
- IDLE:
  - If any req is high, pick the first requester searching ptr+1, ptr+2, ... with wrap mod NUM_REQ.
  - Register gnt one-hot and gnt_id, set ptr=winner, go to BURST. Grant is visible the cycle after req is sampled (1-cycle arbitration latency).
  - If no req is high, stay in IDLE.
- BURST:
  - dp_valid = req[gnt_id] (combinational from the registered gnt_id).
  - dp_data_in = req_data slice gnt_id. When dp_valid=0, dp_data_in holds its last driven value.
  - A beat transfers when dp_valid && dp_ready; the beat counter increments.
  - Burst ends, going to RELEASE the next cycle, on any of:
    - a transfer with req_last[gnt_id]=1;
    - a transfer that makes the beat count equal MAX_BURST;
    - req[gnt_id]=0 while dp_valid=0 (requester withdrew).
  - Requesters other than gnt_id are ignored during BURST.
- RELEASE:
  - gnt=0, dp_valid=0, counters cleared.
  - Lasts exactly one cycle, then IDLE. This guarantees one dead cycle between grants, so the datapath never sees back-to-back beats from different requesters.
- Fairness:
  - After a grant to i, i has lowest priority at the next arbitration.
  - With all NUM_REQ requesting continuously, the grant order is 0,1,2,3,0,...
- Width rules:
  - Beat counter and stall counter are $clog2(MAX_BURST+1) and $clog2(TIMEOUT+1) bits respectively; they saturate and never wrap.
  - gnt_id holds its value through RELEASE and IDLE.
- Simultaneous events:
  - Last beat and MAX_BURST reached in the same cycle: a single end, one RELEASE.
  - Transfer in the same cycle the timeout threshold would be hit: the transfer wins and the stall counter resets.

Optional Feature:
- Macro: SCHED_TIMEOUT_EN.
- Defined:
  - The stall counter increments each BURST cycle with dp_valid=1 and dp_ready=0, and clears on transfer.
  - On reaching TIMEOUT, go to RELEASE and pulse timeout_err for 1 cycle (the cycle the FSM enters RELEASE).
  - The RR pointer still advances past the aborted requester.
- Undefined:
  - No stall counter; a burst waits indefinitely for dp_ready.
  - timeout_err is tied to 0.

Test Plan:
- Reset then req=4'b0001, 3 beats, last on beat 3, dp_ready=1 -> gnt=0001 one cycle after req; exactly 3 transfers; one RELEASE cycle with gnt=0; busy drops in IDLE.
- req=4'b1111 held, each requester sends bursts of 2 with last -> grant order 0,1,2,3,0; exactly one gnt=0 cycle between grants; no beat from a non-granted slice.
- req=4'b0100, no last, 20 beats pending, MAX_BURST=8 -> exactly 8 transfers, RELEASE, then regrant of requester 2 (only requester).
- SCHED_TIMEOUT_EN, TIMEOUT=15, dp_ready=0 for 20 cycles after grant -> timeout_err pulses once, 15 cycles after dp_valid first rises; next grant goes to the next requester in RR order.
- rst pulsed mid-burst after 3 of 6 beats -> all outputs 0 asynchronously; after release, requester 0 wins the first arbitration.
- Requester 1 drops req after 2 beats with no last; requester 3 is pending -> burst ends, RELEASE, gnt=1000.
